// File: rtl/l16_mod_accumulator.sv
// Purpose: per-frame modulo 2^16-1 accumulator (one's-complement residue) with beat count.
// Latency: result valid the cycle after the last beat is accepted.
// Backpressure: in_ready = ~out_valid | out_ready, so a held result stalls input only while untaken.

module L16_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);
    // Ling pseudo-carry form: h_i = g_i | c_i, carry out of bit i = t_i & h_i.
    function automatic logic [16:0] ling_pass(input logic [15:0] x, input logic [15:0] y,
                                              input logic cin);
        logic [15:0] g, t, p, h, s;
        logic [16:0] c;
        g    = x & y;
        t    = x | y;
        p    = x ^ y;
        c    = '0;
        h    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < 16; i++) begin
            h[i]   = g[i] | c[i];
            c[i+1] = t[i] & h[i];
            s[i]   = p[i] ^ c[i];
        end
        return {c[16], s};
    endfunction

    logic [16:0] pass0;
    logic [16:0] pass1;

    // Feeding the carry-out back in cannot produce a second carry, so two passes suffice.
    always_comb begin
        pass0 = ling_pass(a, b, 1'b0);
        pass1 = ling_pass(a, b, pass0[16]);
        sum   = pass1[15:0];
    end
endmodule

module l16_mod_accumulator #(
    parameter int CNT_W     = 8,
    parameter int NORMALIZE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [15:0]      in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [15:0]      out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [15:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      sum_q, sum_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             vld_q, vld_d;

    logic [15:0]      add_sum;
    logic [15:0]      add_norm;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;

    L16_adder u_add (
        .a   (acc_q),
        .b   (in_data),
        .sum (add_sum)
    );

    assign in_ready = ~vld_q | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        add_norm = (NORMALIZE != 0 && add_sum == 16'hFFFF) ? 16'h0000 : add_sum;

        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        count_d = count_q;
        vld_d   = vld_q;

        if (vld_q && out_ready) begin
            vld_d = 1'b0;
        end

        // clr swallows any beat accepted with it, last included, and leaves the output slot alone.
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            if (in_last) begin
                sum_d   = add_norm;
                count_d = cnt_inc;
                vld_d   = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                acc_d = add_sum;
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            count_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            vld_q   <= vld_d;
        end
    end

    assign out_sum   = sum_q;
    assign out_count = count_q;
    assign out_valid = vld_q;
endmodule

// File: tb/tb_l16_mod_accumulator.sv
// Bench for l16_mod_accumulator: a normalizing and a raw instance share one stimulus stream;
// expected frame results are queued at last-beat accept and compared at the output handshake.

module tb_l16_mod_accumulator;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;

    logic        in_ready,  in_ready_r;
    logic [15:0] out_sum,   out_sum_r;
    logic [7:0]  out_count, out_count_r;
    logic        out_valid, out_valid_r;

    typedef struct {
        logic [15:0] s_norm;
        logic [15:0] s_raw;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] m_acc;
    logic [7:0]  m_cnt;
    int          checks = 0;
    int          errors = 0;
    int          vld_cycles = 0;

    always #5 clk = ~clk;

    l16_mod_accumulator #(.CNT_W(8), .NORMALIZE(1)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_sum(out_sum), .out_count(out_count),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    l16_mod_accumulator #(.CNT_W(8), .NORMALIZE(0)) dut_raw (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready_r), .out_sum(out_sum_r), .out_count(out_count_r),
        .out_valid(out_valid_r), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mod_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] t;
        t = {1'b0, a} + {1'b0, b};
        return t[15:0] + {15'd0, t[16]};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    // Monitor: every output handshake must match the oldest queued frame.
    always @(negedge clk) begin
        if (rst_n && out_valid) vld_cycles++;
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("spurious_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sum_norm", out_sum, e.s_norm);
                chk("sum_raw", out_sum_r, e.s_raw);
                chk("count", out_count, e.cnt);
                chk("raw_valid_align", out_valid_r, 1'b1);
            end
        end
    end

    // Presents one beat (inputs stay driven on return) and waits for it to be accepted.
    task automatic beat(input logic [15:0] d, input logic l, input logic c);
        logic [15:0] s;
        int          n;
        in_data  = d;
        in_last  = l;
        clr      = c;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            s = mod_add(m_acc, d);
            if (c) begin
                m_acc = '0;
                m_cnt = '0;
            end else if (l) begin
                sb_q.push_back('{s_norm: (s == 16'hFFFF) ? 16'h0000 : s, s_raw: s,
                                 cnt: sat_inc(m_cnt)});
                m_acc = '0;
                m_cnt = '0;
            end else begin
                m_acc = s;
                m_cnt = sat_inc(m_cnt);
            end
        end
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        clr      = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        m_acc = '0; m_cnt = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_sum", out_sum, 16'h0000);
        chk("rst_count", out_count, 8'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        idle(1);

        // Basic frame with latency and single-cycle valid
        beat(16'h0001, 1'b0, 1'b0);
        beat(16'h0002, 1'b0, 1'b0);
        beat(16'h0003, 1'b1, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat1_valid", out_valid, 1'b1);
        chk("lat1_sum", out_sum, 16'h0006);
        @(negedge clk);
        chk("valid_one_cycle", out_valid, 1'b0);
        idle(1);

        // End-around carry and negative zero
        beat(16'hFFFF, 1'b0, 1'b0);
        beat(16'h0001, 1'b1, 1'b0);
        beat(16'h8000, 1'b0, 1'b0);
        beat(16'h8000, 1'b1, 1'b0);
        beat(16'h1234, 1'b0, 1'b0);
        beat(16'hEDCB, 1'b1, 1'b0);
        idle(3);

        // Backpressure: hold a result, keep an operand offered for 5 cycles
        out_ready = 1'b0;
        beat(16'h0100, 1'b0, 1'b0);
        beat(16'h0200, 1'b1, 1'b0);
        in_data = 16'h0001; in_last = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_sum", out_sum, 16'h0300);
            chk("stall_count", out_count, 8'd2);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1'b1);
        beat(16'h0001, 1'b0, 1'b0);
        beat(16'h0002, 1'b1, 1'b0);
        idle(3);

        // Back-to-back single-beat frames
        vld_cycles = 0;
        beat(16'h0010, 1'b1, 1'b0);
        beat(16'h0020, 1'b1, 1'b0);
        beat(16'h0030, 1'b1, 1'b0);
        idle(3);
        chk("b2b_valid_cycles", vld_cycles, 32'd3);

        // clr with the 2nd beat discards the partial frame
        beat(16'h0005, 1'b0, 1'b0);
        beat(16'h0007, 1'b0, 1'b1);
        beat(16'h0009, 1'b1, 1'b0);
        idle(2);

        // clr on a last beat produces no result
        beat(16'h0004, 1'b1, 1'b1);
        beat(16'h0011, 1'b1, 1'b0);
        idle(2);

        // Reset mid-frame
        beat(16'h0040, 1'b0, 1'b0);
        beat(16'h0050, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_acc = '0; m_cnt = '0;
        rst_n = 1'b1;
        chk("rst_mid_valid", out_valid, 1'b0);
        beat(16'h0003, 1'b1, 1'b0);
        idle(2);

        // Count saturation: 300 beats of 1, sum unaffected
        for (int i = 0; i < 299; i++) beat(16'h0001, 1'b0, 1'b0);
        beat(16'h0001, 1'b1, 1'b0);
        idle(3);
        chk("sat_model_count", sb_q.size(), 32'd0);

        chk("drain_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
